// File: rtl/ext_pipe.sv
// ext_pipe: immediate / load-data extension stage with a two-entry output
// buffer (main register + skid register).
//
// Ports:
//   clk        rising-edge clock for all state
//   reset      synchronous, active-high reset
//   in_valid   upstream word presented
//   in_ready   word accepted this cycle (registered, = NOT skid_valid)
//   in_data    raw immediate or memory word
//   in_mode    extension mode
//   in_sel     byte offset for byte / halfword modes
//   out_valid  result presented
//   out_ready  downstream consumes result this cycle
//   out_data   extended result
//   out_err    misaligned-access flag travelling with out_data
//
// Modes:
//   000 sext imm | 001 zext imm | 010 imm in upper bits
//   011 sext byte | 100 zext byte | 101 sext half | 110 zext half
//   111 zero result with err set
//
// States:
//   EMPTY | no word buffered
//   ONE   | main register holds a word, skid empty
//   FULL  | main and skid registers both hold words, in_ready low
module ext_pipe #(
  parameter  int DATA_W = 32,
  parameter  int IMM_W  = 16,
  localparam int SEL_W  = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_mode,
  input  logic [SEL_W-1:0]  in_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t              state_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_err_q;
  logic [DATA_W-1:0]   skid_data_q;
  logic                skid_err_q;

  logic [DATA_W-1:0]   res_d;
  logic                err_d;
  logic [IMM_W-1:0]    imm;
  logic [7:0]          byte_v;
  logic [15:0]         half_v;
  logic [SEL_W-1:0]    hsel;
  logic                accept;
  logic                consume;

  assign accept  = in_valid & in_ready_q;
  assign consume = out_valid_q & out_ready;

  // Extraction uses shifts so the offset arithmetic stays width-safe for
  // every legal DATA_W; sized casts of signed values perform sign extension.
  always_comb begin
    imm    = in_data[IMM_W-1:0];
    hsel   = in_sel >> 1;
    byte_v = 8'(in_data >> {in_sel, 3'b000});
    half_v = 16'(in_data >> {hsel, 4'b0000});
    res_d  = '0;
    err_d  = 1'b0;
    case (in_mode)
      3'b000: res_d = DATA_W'($signed(imm));
      3'b001: res_d = DATA_W'(imm);
      3'b010: res_d = DATA_W'(imm) << (DATA_W - IMM_W);
      3'b011: res_d = DATA_W'($signed(byte_v));
      3'b100: res_d = DATA_W'(byte_v);
      3'b101: begin
        res_d = DATA_W'($signed(half_v));
        err_d = in_sel[0];
      end
      3'b110: begin
        res_d = DATA_W'(half_v);
        err_d = in_sel[0];
      end
      default: begin
        res_d = '0;
        err_d = 1'b1;
      end
    endcase
  end

  // in_ready_q only changes on entering or leaving FULL, so it never depends
  // combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            out_data_q  <= res_d;
            out_err_q   <= err_d;
            out_valid_q <= 1'b1;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            out_data_q <= res_d;
            out_err_q  <= err_d;
          end else if (accept) begin
            skid_data_q <= res_d;
            skid_err_q  <= err_d;
            in_ready_q  <= 1'b0;
            state_q     <= FULL;
          end else if (consume) begin
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            out_data_q <= skid_data_q;
            out_err_q  <= skid_err_q;
            in_ready_q <= 1'b1;
            state_q    <= ONE;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_ext_pipe.sv
module tb_ext_pipe;

  localparam int DATA_W = 32;
  localparam int IMM_W  = 16;
  localparam int SEL_W  = 2;
  localparam int N_RAND = 10000;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [2:0]        in_mode;
  logic [SEL_W-1:0]  in_sel;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;

  int n_tests = 0;
  int n_fail  = 0;

  ext_pipe #(.DATA_W(DATA_W), .IMM_W(IMM_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {err, data} for DATA_W=32, IMM_W=16.
  function automatic logic [32:0] ref_ext(input logic [2:0] m, input logic [1:0] s,
                                          input logic [31:0] d);
    logic [15:0] im;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    logic        e;
    im = d[15:0];
    b  = d[int'(s) * 8 +: 8];
    h  = s[1] ? d[31:16] : d[15:0];
    e  = 1'b0;
    case (m)
      3'd0: r = {{16{im[15]}}, im};
      3'd1: r = {16'h0000, im};
      3'd2: r = {im, 16'h0000};
      3'd3: r = {{24{b[7]}}, b};
      3'd4: r = {24'h000000, b};
      3'd5: begin r = {{16{h[15]}}, h}; e = s[0]; end
      3'd6: begin r = {16'h0000, h};    e = s[0]; end
      default: begin r = 32'h0; e = 1'b1; end
    endcase
    return {e, r};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single word with out_ready held high: result must appear one cycle later.
  task automatic one_word(input string tag, input logic [2:0] m, input logic [1:0] s,
                          input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e);
    in_valid = 1'b1; in_mode = m; in_sel = s; in_data = d;
    step();
    in_valid = 1'b0; in_data = 32'hDEAD_BEEF;
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_data"}, out_data, exp_d);
    chk({tag, "_err"}, out_err, exp_e);
    step();
    chk({tag, "_drain"}, out_valid, 1'b0);
  endtask

  logic [32:0] q[$];
  logic [32:0] e33;
  int          sent, recv, cyc;
  logic        acc, con, prev_stall, prev_e;
  logic [31:0] prev_d;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_mode = '0; in_sel = '0;
    step();
    step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_err", out_err, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    reset = 1'b0;
    out_ready = 1'b1;

    one_word("m0_sext", 3'd0, 2'd0, 32'h0000_8001, 32'hFFFF_8001, 1'b0);
    one_word("m2_upper", 3'd2, 2'd0, 32'h0000_1234, 32'h1234_0000, 1'b0);
    one_word("m1_zext", 3'd1, 2'd0, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0);
    one_word("m3_sbyte", 3'd3, 2'd2, 32'h0080_0000, 32'hFFFF_FF80, 1'b0);
    one_word("m4_zbyte", 3'd4, 2'd2, 32'h0080_0000, 32'h0000_0080, 1'b0);
    one_word("m5_mis", 3'd5, 2'd3, 32'h0080_0000, 32'h0000_0080, 1'b1);
    one_word("m6_mis", 3'd6, 2'd1, 32'hABCD_1234, 32'h0000_1234, 1'b1);
    one_word("m5_hi", 3'd5, 2'd2, 32'h8001_0000, 32'hFFFF_8001, 1'b0);
    one_word("m7_err", 3'd7, 2'd0, 32'h1234_5678, 32'h0000_0000, 1'b1);

    // Back-to-back with downstream stalled.
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 3'd1; in_sel = 2'd0; in_data = 32'h0000_0011;
    step();
    chk("bp_ready_after1", in_ready, 1'b1);
    in_data = 32'h0000_0022;
    step();
    chk("bp_ready_after2", in_ready, 1'b0);
    chk("bp_head", out_data, 32'h11);
    in_data = 32'h0000_0033;
    step();
    chk("bp_still_blocked", in_ready, 1'b0);
    chk("bp_hold", out_data, 32'h11);
    out_ready = 1'b1;
    step();
    chk("bp_second", out_data, 32'h22);
    chk("bp_ready_back", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("bp_third", out_data, 32'h33);
    chk("bp_third_valid", out_valid, 1'b1);
    step();
    chk("bp_empty", out_valid, 1'b0);

    // Random traffic against a reference queue.
    sent = 0; recv = 0; cyc = 0; prev_stall = 1'b0; prev_d = '0; prev_e = 1'b0;
    while ((sent < N_RAND || recv < N_RAND) && cyc < 60000) begin
      if (prev_stall) begin
        chk("rand_stall_data", out_data, prev_d);
        chk("rand_stall_err", out_err, prev_e);
      end
      in_valid  = (sent < N_RAND) && ($urandom_range(0, 1) == 1);
      in_mode   = 3'($urandom_range(0, 7));
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 1) == 1);
      acc = in_valid && in_ready;
      con = out_valid && out_ready;
      if (con) begin
        if (q.size() == 0) begin
          chk("rand_spurious", 1'b1, 1'b0);
        end else begin
          e33 = q.pop_front();
          chk("rand_data", out_data, e33[31:0]);
          chk("rand_err", out_err, e33[32]);
          recv++;
        end
      end
      if (acc) begin
        q.push_back(ref_ext(in_mode, in_sel, in_data));
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_e = out_err;
      step();
      cyc++;
    end
    chk("rand_received", recv, N_RAND);
    chk("rand_q_empty", q.size(), 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    chk("rand_idle", out_valid, 1'b0);

    // Reset while FULL, and no accept while reset is high.
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 3'd1; in_sel = 2'd0; in_data = 32'h0000_00A1;
    step();
    in_data = 32'h0000_00A2;
    step();
    chk("full_before_rst", in_ready, 1'b0);
    reset = 1'b1;
    in_data = 32'h0000_00A3;
    step();
    chk("rst_full_valid", out_valid, 1'b0);
    chk("rst_full_ready", in_ready, 1'b1);
    chk("rst_full_data", out_data, 32'h0);
    in_data = 32'h0000_00A4;
    step();
    chk("rst_no_accept", out_valid, 1'b0);
    reset = 1'b0;
    out_ready = 1'b1;
    in_data = 32'h0000_00A5;
    step();
    in_valid = 1'b0;
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_data", out_data, 32'hA5);
    step();
    chk("post_rst_alone", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
